// File: rtl/t_switch_pkg.sv
// Shared types, port indices and helper functions for the age-arbitrated
// 3-port T-switch (left / right / up).
package t_switch_pkg;

    typedef logic [1:0] port_t;

    localparam port_t P_L    = 2'd0;
    localparam port_t P_R    = 2'd1;
    localparam port_t P_U    = 2'd2;
    localparam port_t P_NONE = 2'd3;

    // Widest age field the saturating-increment helper supports.
    localparam int AGE_MAX_W = 8;

    // Rotation table: tie-break rank of a port for a given pointer value
    // (rank 0 wins). ptr=0 -> L,R,U ; ptr=1 -> R,U,L ; ptr=2 -> U,L,R.
    function automatic logic [1:0] port_rank(input logic [1:0] ptr, input port_t port);
        logic [1:0] rank;
        case ({ptr, port})
            {2'd0, P_L}: rank = 2'd0;
            {2'd0, P_R}: rank = 2'd1;
            {2'd0, P_U}: rank = 2'd2;
            {2'd1, P_L}: rank = 2'd2;
            {2'd1, P_R}: rank = 2'd0;
            {2'd1, P_U}: rank = 2'd1;
            {2'd2, P_L}: rank = 2'd1;
            {2'd2, P_R}: rank = 2'd2;
            {2'd2, P_U}: rank = 2'd0;
            default:     rank = 2'd3;
        endcase
        return rank;
    endfunction

    // Pointer sequence 0 -> 1 -> 2 -> 0; an illegal value recovers to 0.
    function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
        logic [1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Increment an age of width w (w <= AGE_MAX_W), saturating at 2^w-1.
    function automatic logic [AGE_MAX_W-1:0] age_sat_inc(input logic [AGE_MAX_W-1:0] age,
                                                         input int unsigned w);
        logic [AGE_MAX_W-1:0] max_v;
        logic [AGE_MAX_W-1:0] res;
        max_v = {AGE_MAX_W{1'b1}} >> (AGE_MAX_W - w);
        if (age >= max_v) begin
            res = max_v;
        end else begin
            res = age + {{(AGE_MAX_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/t_switch_alloc.sv
// Combinational output allocator: orders valid inputs by age (ptr breaks
// ties), grants each its desired port if free, otherwise deflects it to
// the first free port of {own, L, R, U}. Never drops a valid input.
module t_switch_alloc
    import t_switch_pkg::*;
#(
    parameter int AGE_W = 3
) (
    input  logic [2:0]       v,
    input  port_t            des [3],
    input  logic [AGE_W-1:0] age [3],
    input  logic [1:0]       ptr,
    output port_t            sel [3],
    output logic [2:0]       defl
);

    logic [1:0] rank_s [3];
    logic [1:0] pos_s  [3];

    // Tie-break rank of each input under the current pointer.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rank_s[i] = port_rank(ptr, port_t'(i));
        end
    end

    // Priority position of each input = number of valid inputs that beat it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pos_s[i] = 2'd0;
            for (int j = 0; j < 3; j++) begin
                if ((j != i) && v[j] &&
                    ((age[j] > age[i]) || ((age[j] == age[i]) && (rank_s[j] < rank_s[i])))) begin
                    pos_s[i] = pos_s[i] + 2'd1;
                end else begin
                    pos_s[i] = pos_s[i];
                end
            end
        end
    end

    // Walk inputs in priority order and hand out output ports.
    always_comb begin : alloc_walk
        logic [2:0] free_s;
        logic       take_s;
        free_s = 3'b111;
        take_s = 1'b0;
        defl   = 3'b000;
        for (int o = 0; o < 3; o++) begin
            sel[o] = P_NONE;
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) begin
                if (v[i] && (pos_s[i] == 2'(p))) begin
                    take_s = 1'b0;
                    // desired port
                    for (int o = 0; o < 3; o++) begin
                        if (!take_s && (des[i] == port_t'(o)) && free_s[o]) begin
                            sel[o]    = port_t'(i);
                            free_s[o] = 1'b0;
                            take_s    = 1'b1;
                        end else begin
                            take_s = take_s;
                        end
                    end
                    // deflection: own arrival port first
                    for (int o = 0; o < 3; o++) begin
                        if (!take_s && (o == i) && free_s[o]) begin
                            sel[o]    = port_t'(i);
                            free_s[o] = 1'b0;
                            take_s    = 1'b1;
                            defl[i]   = 1'b1;
                        end else begin
                            take_s = take_s;
                        end
                    end
                    // deflection: then L, R, U
                    for (int o = 0; o < 3; o++) begin
                        if (!take_s && free_s[o]) begin
                            sel[o]    = port_t'(i);
                            free_s[o] = 1'b0;
                            take_s    = 1'b1;
                            defl[i]   = 1'b1;
                        end else begin
                            take_s = take_s;
                        end
                    end
                end else begin
                    free_s = free_s;
                end
            end
        end
    end

endmodule

// File: rtl/t_switch_age.sv
// Registered 3-port deflection T-switch carrying full packets. Decodes
// destinations, allocates outputs by age, registers results with one
// ce-cycle latency and counts deflections (saturating).
module t_switch_age
    import t_switch_pkg::*;
#(
    parameter int N     = 8,
    parameter int A_W   = $clog2(N) + 1,
    parameter int D_W   = 32,
    parameter int AGE_W = 3,
    parameter int POSL  = 0,
    parameter int POSX  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr_cnt,
    input  logic             l_i_v,
    input  logic [A_W-1:0]   l_i_addr,
    input  logic [D_W-1:0]   l_i_data,
    input  logic [AGE_W-1:0] l_i_age,
    input  logic             r_i_v,
    input  logic [A_W-1:0]   r_i_addr,
    input  logic [D_W-1:0]   r_i_data,
    input  logic [AGE_W-1:0] r_i_age,
    input  logic             u_i_v,
    input  logic [A_W-1:0]   u_i_addr,
    input  logic [D_W-1:0]   u_i_data,
    input  logic [AGE_W-1:0] u_i_age,
    output logic             l_o_v,
    output logic [A_W-1:0]   l_o_addr,
    output logic [D_W-1:0]   l_o_data,
    output logic [AGE_W-1:0] l_o_age,
    output logic             l_o_defl,
    output logic             r_o_v,
    output logic [A_W-1:0]   r_o_addr,
    output logic [D_W-1:0]   r_o_data,
    output logic [AGE_W-1:0] r_o_age,
    output logic             r_o_defl,
    output logic             u_o_v,
    output logic [A_W-1:0]   u_o_addr,
    output logic [D_W-1:0]   u_o_data,
    output logic [AGE_W-1:0] u_o_age,
    output logic             u_o_defl,
    output logic [CNT_W-1:0] defl_cnt
);

    // L/R inputs go up unless the destination lies under this switch;
    // locally, addr[POSL] picks the child.
    function automatic port_t lr_desire(input logic [A_W-1:0] addr);
        port_t d;
        if ((addr >> (POSL + 1)) == A_W'(POSX)) begin
            d = addr[POSL] ? P_R : P_L;
        end else begin
            d = P_U;
        end
        return d;
    endfunction

    logic [2:0]       in_v_s;
    logic [A_W-1:0]   in_addr_s [3];
    logic [D_W-1:0]   in_data_s [3];
    logic [AGE_W-1:0] in_age_s  [3];
    logic [AGE_W-1:0] age_inc_s [3];
    port_t            des_s     [3];
    port_t            sel_s     [3];
    logic [2:0]       defl_s;

    logic             nxt_v_s    [3];
    logic             nxt_defl_s [3];
    logic [A_W-1:0]   nxt_addr_s [3];
    logic [D_W-1:0]   nxt_data_s [3];
    logic [AGE_W-1:0] nxt_age_s  [3];

    logic [1:0]       n_defl_s;
    logic [CNT_W:0]   cnt_sum_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             out_v_r    [3];
    logic             out_defl_r [3];
    logic [A_W-1:0]   out_addr_r [3];
    logic [D_W-1:0]   out_data_r [3];
    logic [AGE_W-1:0] out_age_r  [3];
    logic [1:0]       ptr_r;
    logic [CNT_W-1:0] defl_cnt_r;

    assign in_v_s = {u_i_v, r_i_v, l_i_v};

    // Gather inputs into port-indexed arrays and decode desired outputs.
    always_comb begin
        in_addr_s[P_L] = l_i_addr;
        in_addr_s[P_R] = r_i_addr;
        in_addr_s[P_U] = u_i_addr;
        in_data_s[P_L] = l_i_data;
        in_data_s[P_R] = r_i_data;
        in_data_s[P_U] = u_i_data;
        in_age_s[P_L]  = l_i_age;
        in_age_s[P_R]  = r_i_age;
        in_age_s[P_U]  = u_i_age;
        des_s[P_L]     = lr_desire(l_i_addr);
        des_s[P_R]     = lr_desire(r_i_addr);
        des_s[P_U]     = u_i_addr[POSL] ? P_R : P_L;
        for (int i = 0; i < 3; i++) begin
            age_inc_s[i] = AGE_W'(age_sat_inc(AGE_MAX_W'(in_age_s[i]), AGE_W));
        end
    end

    t_switch_alloc #(
        .AGE_W (AGE_W)
    ) u_alloc (
        .v    (in_v_s),
        .des  (des_s),
        .age  (in_age_s),
        .ptr  (ptr_r),
        .sel  (sel_s),
        .defl (defl_s)
    );

    // Route the selected input packet onto each output; idle outputs are zero.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            nxt_v_s[o]    = 1'b0;
            nxt_defl_s[o] = 1'b0;
            nxt_addr_s[o] = '0;
            nxt_data_s[o] = '0;
            nxt_age_s[o]  = '0;
            for (int i = 0; i < 3; i++) begin
                if (sel_s[o] == port_t'(i)) begin
                    nxt_v_s[o]    = 1'b1;
                    nxt_defl_s[o] = defl_s[i];
                    nxt_addr_s[o] = in_addr_s[i];
                    nxt_data_s[o] = in_data_s[i];
                    nxt_age_s[o]  = defl_s[i] ? age_inc_s[i] : in_age_s[i];
                end else begin
                    nxt_v_s[o] = nxt_v_s[o];
                end
            end
        end
    end

    // Next deflection count: add this cycle's deflections, saturate, or clear.
    always_comb begin
        n_defl_s  = {1'b0, defl_s[0]} + {1'b0, defl_s[1]} + {1'b0, defl_s[2]};
        cnt_sum_s = {1'b0, defl_cnt_r} + {{(CNT_W-1){1'b0}}, n_defl_s};
        if (clr_cnt) begin
            cnt_nxt_s = '0;
        end else if (cnt_sum_s[CNT_W]) begin
            cnt_nxt_s = {CNT_W{1'b1}};
        end else begin
            cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Output packet registers, tie-break pointer and deflection counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 3; o++) begin
                out_v_r[o]    <= 1'b0;
                out_defl_r[o] <= 1'b0;
                out_addr_r[o] <= '0;
                out_data_r[o] <= '0;
                out_age_r[o]  <= '0;
            end
            ptr_r      <= 2'd0;
            defl_cnt_r <= '0;
        end else if (ce) begin
            for (int o = 0; o < 3; o++) begin
                out_v_r[o]    <= nxt_v_s[o];
                out_defl_r[o] <= nxt_defl_s[o];
                out_addr_r[o] <= nxt_addr_s[o];
                out_data_r[o] <= nxt_data_s[o];
                out_age_r[o]  <= nxt_age_s[o];
            end
            ptr_r      <= ptr_next(ptr_r);
            defl_cnt_r <= cnt_nxt_s;
        end
    end

    assign l_o_v    = out_v_r[P_L];
    assign l_o_defl = out_defl_r[P_L];
    assign l_o_addr = out_addr_r[P_L];
    assign l_o_data = out_data_r[P_L];
    assign l_o_age  = out_age_r[P_L];
    assign r_o_v    = out_v_r[P_R];
    assign r_o_defl = out_defl_r[P_R];
    assign r_o_addr = out_addr_r[P_R];
    assign r_o_data = out_data_r[P_R];
    assign r_o_age  = out_age_r[P_R];
    assign u_o_v    = out_v_r[P_U];
    assign u_o_defl = out_defl_r[P_U];
    assign u_o_addr = out_addr_r[P_U];
    assign u_o_data = out_data_r[P_U];
    assign u_o_age  = out_age_r[P_U];
    assign defl_cnt = defl_cnt_r;

endmodule

// File: tb/tb_t_switch_age.sv
// Self-checking bench for t_switch_age: directed scenarios followed by
// randomized traffic, all compared against a packet-level reference model.
module tb_t_switch_age;

    localparam int N     = 8;
    localparam int A_W   = 4;
    localparam int D_W   = 32;
    localparam int AGE_W = 3;
    localparam int POSL  = 0;
    localparam int POSX  = 0;
    localparam int CNT_W = 4;
    localparam int AGE_MAX = (1 << AGE_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic clr_cnt;

    logic             iv    [3];
    logic [A_W-1:0]   iaddr [3];
    logic [D_W-1:0]   idata [3];
    logic [AGE_W-1:0] iage  [3];

    logic             ov    [3];
    logic [A_W-1:0]   oaddr [3];
    logic [D_W-1:0]   odata [3];
    logic [AGE_W-1:0] oage  [3];
    logic             odefl [3];
    logic [CNT_W-1:0] defl_cnt;

    // reference model state
    logic             e_v    [3];
    logic             e_defl [3];
    logic [A_W-1:0]   e_addr [3];
    logic [D_W-1:0]   e_data [3];
    logic [AGE_W-1:0] e_age  [3];
    int               e_cnt;
    int               m_ptr;

    int n_vec = 0;
    int n_miscmp = 0;
    int saved_cnt;
    string port_tag [3] = '{"l_o", "r_o", "u_o"};

    t_switch_age #(
        .N(N), .A_W(A_W), .D_W(D_W), .AGE_W(AGE_W),
        .POSL(POSL), .POSX(POSX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .clr_cnt(clr_cnt),
        .l_i_v(iv[0]), .l_i_addr(iaddr[0]), .l_i_data(idata[0]), .l_i_age(iage[0]),
        .r_i_v(iv[1]), .r_i_addr(iaddr[1]), .r_i_data(idata[1]), .r_i_age(iage[1]),
        .u_i_v(iv[2]), .u_i_addr(iaddr[2]), .u_i_data(idata[2]), .u_i_age(iage[2]),
        .l_o_v(ov[0]), .l_o_addr(oaddr[0]), .l_o_data(odata[0]), .l_o_age(oage[0]), .l_o_defl(odefl[0]),
        .r_o_v(ov[1]), .r_o_addr(oaddr[1]), .r_o_data(odata[1]), .r_o_age(oage[1]), .r_o_defl(odefl[1]),
        .u_o_v(ov[2]), .u_o_addr(oaddr[2]), .u_o_data(odata[2]), .u_o_age(oage[2]), .u_o_defl(odefl[2]),
        .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Destination port a packet wants, from the routing rules.
    function automatic int desire(input int i);
        int a;
        int bit_sel;
        a = int'(iaddr[i]);
        bit_sel = (a >> POSL) & 1;
        if (i == 2) return bit_sel;
        if ((a >> (POSL + 1)) == POSX) return bit_sel;
        return 2;
    endfunction

    // Does input a win arbitration over input b?
    function automatic bit beats(input int a, input int b);
        int ra;
        int rb;
        ra = (a - m_ptr + 3) % 3;
        rb = (b - m_ptr + 3) % 3;
        if (iage[a] != iage[b]) return iage[a] > iage[b];
        return ra < rb;
    endfunction

    task automatic m_reset();
        for (int o = 0; o < 3; o++) begin
            e_v[o] = 0; e_defl[o] = 0; e_addr[o] = '0; e_data[o] = '0; e_age[o] = '0;
        end
        e_cnt = 0;
        m_ptr = 0;
    endtask

    // Model the edge about to happen using the inputs currently driven.
    task automatic model_step();
        int cand[$];
        int order[$];
        bit taken[3];
        int ndefl;
        int best;
        int pick;
        int d;
        int tries[4];
        if (!ce) return;
        for (int i = 0; i < 3; i++) if (iv[i]) cand.push_back(i);
        while (cand.size() > 0) begin
            best = 0;
            for (int k = 1; k < cand.size(); k++) if (beats(cand[k], cand[best])) best = k;
            order.push_back(cand[best]);
            cand.delete(best);
        end
        for (int o = 0; o < 3; o++) begin
            e_v[o] = 0; e_defl[o] = 0; e_addr[o] = '0; e_data[o] = '0; e_age[o] = '0;
            taken[o] = 0;
        end
        ndefl = 0;
        foreach (order[n]) begin
            int i;
            i = order[n];
            d = desire(i);
            pick = -1;
            if (!taken[d]) pick = d;
            else begin
                tries = '{i, 0, 1, 2};
                foreach (tries[t]) if (pick < 0 && !taken[tries[t]]) pick = tries[t];
            end
            taken[pick] = 1;
            e_v[pick] = 1;
            e_addr[pick] = iaddr[i];
            e_data[pick] = idata[i];
            e_defl[pick] = (pick != d);
            if (pick != d) begin
                ndefl++;
                e_age[pick] = AGE_W'((int'(iage[i]) + 1 > AGE_MAX) ? AGE_MAX : int'(iage[i]) + 1);
            end else begin
                e_age[pick] = iage[i];
            end
        end
        if (clr_cnt) e_cnt = 0;
        else e_cnt = (e_cnt + ndefl > CNT_MAX) ? CNT_MAX : e_cnt + ndefl;
        m_ptr = (m_ptr + 1) % 3;
    endtask

    task automatic compare_all();
        for (int o = 0; o < 3; o++) begin
            check_eq(port_tag[o],
                     64'({ov[o], odefl[o], oage[o], oaddr[o], odata[o]}),
                     64'({e_v[o], e_defl[o], e_age[o], e_addr[o], e_data[o]}));
        end
        check_eq("defl_cnt", 64'(defl_cnt), 64'(e_cnt));
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            iaddr[i] = A_W'($urandom);
            idata[i] = $urandom;
            iage[i] = AGE_W'($urandom);
        end
    endtask

    task automatic set_in(input int p, input int addr, input int data, input int age);
        iv[p] = 1'b1;
        iaddr[p] = A_W'(addr);
        idata[p] = D_W'(data);
        iage[p] = AGE_W'(age);
    endtask

    task automatic rand_in();
        for (int i = 0; i < 3; i++) begin
            iv[i] = ($urandom_range(0, 9) < 6);
            iaddr[i] = A_W'($urandom);
            idata[i] = $urandom;
            iage[i] = AGE_W'($urandom);
        end
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; clr_cnt = 1'b0;
        clear_in();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
        ce = 1'b1;

        // 1: single packet to client 1 -> right output
        clear_in(); set_in(0, 1, 32'hA5, 0);
        run_cycle();
        check_eq("t1_r_v", 64'(ov[1]), 64'd1);
        check_eq("t1_r_data", 64'(odata[1]), 64'hA5);

        // 2: older U packet wins R; L packet deflected to its own port
        clear_in(); set_in(0, 1, 32'h11, 3); set_in(2, 1, 32'h22, 5);
        run_cycle();
        check_eq("t2_l_age", 64'(oage[0]), 64'd4);
        check_eq("t2_cnt", 64'(defl_cnt), 64'd1);

        clear_in(); run_cycle();   // advance ptr to 0

        // 3: tie for U under ptr=0 then ptr=1
        clear_in(); set_in(0, 5, 32'h33, 0); set_in(1, 6, 32'h44, 0);
        run_cycle();
        check_eq("t3a_u_addr", 64'(oaddr[2]), 64'd5);
        check_eq("t3a_r_defl", 64'(odefl[1]), 64'd1);
        clear_in(); set_in(0, 5, 32'h55, 0); set_in(1, 6, 32'h66, 0);
        run_cycle();
        check_eq("t3b_u_addr", 64'(oaddr[2]), 64'd6);
        check_eq("t3b_l_defl", 64'(odefl[0]), 64'd1);

        clear_in(); run_cycle();   // ptr back to 0

        // 4: three-way contention for L, age saturation
        clear_in(); set_in(0, 0, 32'h77, 7); set_in(1, 0, 32'h88, 7); set_in(2, 0, 32'h99, 0);
        run_cycle();
        check_eq("t4_r_age", 64'(oage[1]), 64'd7);
        check_eq("t4_u_age", 64'(oage[2]), 64'd1);
        check_eq("t4_cnt", 64'(defl_cnt), 64'd5);

        // 5: clock enable low holds everything, even clr_cnt
        saved_cnt = e_cnt;
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            clr_cnt = (k == 1);
            run_cycle();
        end
        check_eq("t5_hold_cnt", 64'(defl_cnt), 64'(saved_cnt));
        ce = 1'b1; clr_cnt = 1'b1; clear_in();
        run_cycle();
        check_eq("t5_clr_cnt", 64'(defl_cnt), 64'd0);
        clr_cnt = 1'b0;

        // 6: asynchronous reset in the middle of traffic
        clear_in(); set_in(0, 0, 32'h1234, 2); set_in(2, 3, 32'h5678, 1);
        run_cycle();
        rand_in();
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
        clear_in(); set_in(0, 5, 32'hAB, 0); set_in(1, 6, 32'hCD, 0);
        run_cycle();
        check_eq("t6_ptr0_u_addr", 64'(oaddr[2]), 64'd5);
        clear_in(); set_in(0, 1, 32'hA5, 0);
        run_cycle();
        check_eq("t6_r_data", 64'(odata[1]), 64'hA5);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            rand_in();
            ce = ($urandom_range(0, 99) < 85);
            clr_cnt = ($urandom_range(0, 99) < 4);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
